// File: rtl/jt12_host_pkg.sv
// Shared types and entry layout for the JT12 host-side register writer.
// An entry is {part, reg[7:0], data[7:0]} packed into 17 bits.
package jt12_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_HI  = 3'd1,
    ST_ADDR_LO  = 3'd2,
    ST_DATA_HI  = 3'd3,
    ST_DATA_LO  = 3'd4,
    ST_SETTLE_W = 3'd5,
    ST_BUSY_W   = 3'd6
  } wr_state_e;

  localparam int ENTRY_W  = 17;
  localparam int PART_BIT = 16;
  localparam int REG_MSB  = 15;
  localparam int REG_LSB  = 8;
  localparam int DATA_MSB = 7;

  // {part, reg}: the chip-side register address an entry targets
  function automatic logic [8:0] entry_addr(input logic [ENTRY_W-1:0] e);
    return e[PART_BIT:REG_LSB];
  endfunction

endpackage

// File: rtl/jt12_host_fifo.sv
// Single-clock FIFO holding queued register writes; flush empties it at the next edge
// and drops any push offered in the same cycle.
module jt12_host_fifo
  import jt12_host_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = ENTRY_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  ready_o,
  output logic                  empty_o,
  output logic                  empty_next_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  ready_q, empty_q;
  logic                  do_push, do_pop;

  assign do_push = push_i && ready_q && !flush_i;
  assign do_pop  = pop_i && !empty_q && !flush_i;
  assign level_d = flush_i ? '0
                 : level_q + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);

  // NOTE: storage has no reset; only the pointers and level define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      ready_q <= (level_d != LEVEL_FULL);
      empty_q <= (level_d == '0);
    end
  end

  assign rdata_o      = mem_q[rd_ptr_q];
  assign level_o      = level_q;
  assign ready_o      = ready_q;
  assign empty_o      = empty_q;
  assign empty_next_o = (level_d == '0);

endmodule

// File: rtl/jt12_host_writer.sv
// Replays queued JT12 register writes as address/data strobe pairs, then waits for busy.
// Optional JT12_WR_ADDR_CACHE_EN skips the address phase when the address is unchanged.
module jt12_host_writer
  import jt12_host_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int HOLD       = 2,
  parameter int SETTLE     = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_part_i,
  input  logic [7:0]            cmd_reg_i,
  input  logic [7:0]            cmd_data_i,
  input  logic                  flush_i,
  output logic [1:0]            ym_addr_o,
  output logic [7:0]            ym_din_o,
  output logic                  ym_write_o,
  input  logic                  ym_busy_i,
  output logic                  idle_o,
  output logic [DEPTH_LOG2:0]   fifo_level_o,
  output logic                  timeout_err_o,
  input  logic                  clr_err_i
);

  localparam int CNT_W = $clog2(TIMEOUT + HOLD + SETTLE + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  wr_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ENTRY_W-1:0]   held_q, held_d;
  logic [1:0]           addr_q, addr_d;
  logic [7:0]           din_q, din_d;
  logic                 write_q, write_d;
  logic                 idle_q;
  logic                 err_q, err_d;

  logic [ENTRY_W-1:0]   fifo_rdata;
  logic                 fifo_pop, fifo_ready, fifo_empty, fifo_empty_next;
  logic [DEPTH_LOG2:0]  fifo_level;
  logic                 seq_timeout;
  logic                 cache_hit;

  jt12_host_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (cmd_valid_i),
    .pop_i        (fifo_pop),
    .flush_i      (flush_i),
    .wdata_i      ({cmd_part_i, cmd_reg_i, cmd_data_i}),
    .rdata_o      (fifo_rdata),
    .level_o      (fifo_level),
    .ready_o      (fifo_ready),
    .empty_o      (fifo_empty),
    .empty_next_o (fifo_empty_next)
  );

`ifdef JT12_WR_ADDR_CACHE_EN
  logic       cache_valid_q;
  logic [8:0] cache_addr_q;
  logic       seq_ok;

  assign seq_ok    = (state_q == ST_BUSY_W) && !ym_busy_i;
  assign cache_hit = cache_valid_q && (cache_addr_q == entry_addr(fifo_rdata));

  // A flush in the same cycle as a completion still invalidates
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
    end else if (flush_i || seq_timeout) begin
      cache_valid_q <= 1'b0;
    end else if (seq_ok) begin
      cache_valid_q <= 1'b1;
      cache_addr_q  <= entry_addr(held_q);
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    held_d      = held_q;
    addr_d      = addr_q;
    din_d       = din_q;
    write_d     = write_q;
    fifo_pop    = 1'b0;
    seq_timeout = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty && !flush_i) begin
          fifo_pop = 1'b1;
          held_d   = fifo_rdata;
          write_d  = 1'b1;
          if (cache_hit) begin
            state_d = ST_DATA_HI;
            addr_d  = {fifo_rdata[PART_BIT], 1'b1};
            din_d   = fifo_rdata[DATA_MSB:0];
          end else begin
            state_d = ST_ADDR_HI;
            addr_d  = {fifo_rdata[PART_BIT], 1'b0};
            din_d   = fifo_rdata[REG_MSB:REG_LSB];
          end
        end
      end
      ST_ADDR_HI: if (cnt_q == HOLD_LAST) begin
        write_d = 1'b0;
        state_d = ST_ADDR_LO;
        cnt_d   = '0;
      end
      ST_ADDR_LO: if (cnt_q == HOLD_LAST) begin
        addr_d  = {held_q[PART_BIT], 1'b1};
        din_d   = held_q[DATA_MSB:0];
        write_d = 1'b1;
        state_d = ST_DATA_HI;
        cnt_d   = '0;
      end
      ST_DATA_HI: if (cnt_q == HOLD_LAST) begin
        write_d = 1'b0;
        state_d = ST_DATA_LO;
        cnt_d   = '0;
      end
      ST_DATA_LO: if (cnt_q == HOLD_LAST) begin
        state_d = ST_SETTLE_W;
        cnt_d   = '0;
      end
      ST_SETTLE_W: if (cnt_q == SETTLE_LAST) begin
        state_d = ST_BUSY_W;
        cnt_d   = '0;
      end
      ST_BUSY_W: begin
        if (!ym_busy_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          seq_timeout = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A timeout in the same cycle as clr_err leaves the flag set
    err_d = seq_timeout ? 1'b1 : (clr_err_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      write_q <= 1'b0;
      idle_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      write_q <= write_d;
      idle_q  <= (state_d == ST_IDLE) && fifo_empty_next;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o   = fifo_ready;
  assign fifo_level_o  = fifo_level;
  assign ym_addr_o     = addr_q;
  assign ym_din_o      = din_q;
  assign ym_write_o    = write_q;
  assign idle_o        = idle_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_jt12_host_writer.sv
// Bench for jt12_host_writer: directed scenarios plus random traffic, checked every
// cycle against a queue-based model that times each write from its pop cycle.
module tb_jt12_host_writer;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int HOLD       = 2;
  localparam int SETTLE     = 2;
  localparam int TIMEOUT    = 1023;
  localparam int SEQ_LEN    = 4 * HOLD + SETTLE;
`ifdef JT12_WR_ADDR_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_part = 1'b0;
  logic [7:0]          cmd_reg = '0;
  logic [7:0]          cmd_data = '0;
  logic                flush = 1'b0;
  logic [1:0]          ym_addr;
  logic [7:0]          ym_din;
  logic                ym_write;
  logic                ym_busy = 1'b0;
  logic                idle;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                timeout_err;
  logic                clr_err = 1'b0;

  always #5 clk = ~clk;

  jt12_host_writer #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .HOLD       (HOLD),
    .SETTLE     (SETTLE),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_part_i    (cmd_part),
    .cmd_reg_i     (cmd_reg),
    .cmd_data_i    (cmd_data),
    .flush_i       (flush),
    .ym_addr_o     (ym_addr),
    .ym_din_o      (ym_din),
    .ym_write_o    (ym_write),
    .ym_busy_i     (ym_busy),
    .idle_o        (idle),
    .fifo_level_o  (fifo_level),
    .timeout_err_o (timeout_err),
    .clr_err_i     (clr_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic       p;
    logic [7:0] r;
    logic [7:0] d;
  } ent_t;

  ent_t       mq[$];
  ent_t       m_cur;
  bit         m_on = 1'b0;
  bit         m_ifl = 1'b0;   // a write sequence is in flight
  int         m_k = 0;        // cycles since its pop edge
  logic       m_write = 1'b0;
  logic [1:0] m_addr = '0;
  logic [7:0] m_din = '0;
  logic       m_err = 1'b0;
  bit         m_cv = 1'b0;
  logic [8:0] m_ca = '0;
  int         m_sz0;
  bit         m_tmo;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_on = 1'b1; m_ifl = 1'b0; m_k = 0;
      m_write = 1'b0; m_addr = '0; m_din = '0; m_err = 1'b0;
      m_cv = 1'b0; m_ca = '0;
    end else if (m_on) begin
      m_sz0 = mq.size();
      m_tmo = 1'b0;
      if (m_ifl) begin
        if (m_k >= SEQ_LEN && !ym_busy) begin
          m_ifl = 1'b0;
          m_cv  = 1'b1;
          m_ca  = {m_cur.p, m_cur.r};
        end else if (m_k >= SEQ_LEN && (m_k - SEQ_LEN) == TIMEOUT - 1) begin
          m_ifl = 1'b0;
          m_cv  = 1'b0;
          m_tmo = 1'b1;
          m_err = 1'b1;
        end else begin
          m_k++;
        end
      end else if (m_sz0 != 0 && !flush) begin
        m_cur = mq.pop_front();
        m_ifl = 1'b1;
        m_k   = (CACHE_ON && m_cv && m_ca == {m_cur.p, m_cur.r}) ? 2 * HOLD : 0;
      end
      if (!m_tmo && clr_err) m_err = 1'b0;
      if (flush) begin
        mq.delete();
        m_cv = 1'b0;
      end else if (cmd_valid && m_sz0 < DEPTH) begin
        mq.push_back('{p: cmd_part, r: cmd_reg, d: cmd_data});
      end
      if (m_ifl) begin
        m_write = (m_k < HOLD) || (m_k >= 2 * HOLD && m_k < 3 * HOLD);
        if (m_k < 2 * HOLD) begin
          m_addr = {m_cur.p, 1'b0};
          m_din  = m_cur.r;
        end else begin
          m_addr = {m_cur.p, 1'b1};
          m_din  = m_cur.d;
        end
      end else begin
        m_write = 1'b0;
      end
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (m_on) begin
      check("ym_write",    32'(ym_write),    32'(m_write));
      check("ym_addr",     32'(ym_addr),     32'(m_addr));
      check("ym_din",      32'(ym_din),      32'(m_din));
      check("fifo_level",  32'(fifo_level),  32'(mq.size()));
      check("cmd_ready",   32'(cmd_ready),   32'(mq.size() < DEPTH));
      check("idle",        32'(idle),        32'(!m_ifl && mq.size() == 0));
      check("timeout_err", 32'(timeout_err), 32'(m_err));
    end
  end

  // ---------------- strobe log and busy source ----------------
  typedef struct {
    int         c;
    logic [1:0] a;
    logic [7:0] d;
  } strobe_t;

  strobe_t slog[$];
  bit      prev_w = 1'b0;
  bit      rise;
  int      busy_mode = 0;   // 0 low, 1 core-like pulse after data strobe, 2 stuck high, 3 random
  int      busy_len = 5;
  int      busy_cnt = 0;

  always @(negedge clk) begin
    rise = (ym_write === 1'b1) && !prev_w;
    if (rise) slog.push_back('{c: cyc, a: ym_addr, d: ym_din});
    prev_w = (ym_write === 1'b1);
    case (busy_mode)
      0: ym_busy = 1'b0;
      1: begin
        if (rise && ym_addr[0]) busy_cnt = busy_len;
        ym_busy = (busy_cnt != 0);
        if (busy_cnt != 0) busy_cnt--;
      end
      2: ym_busy = 1'b1;
      default: ym_busy = ($urandom_range(0, 2) == 0);
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic push1(input logic p, input logic [7:0] r, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_part = p; cmd_reg = r; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (idle !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(idle), 32'd1);
  endtask

  int         s0, nd, guard, i, t_err, max_lvl;
  bit         rdy, saw_full;
  logic [7:0] regs [4];

  initial begin
    regs[0] = 8'hA4; regs[1] = 8'h28; regs[2] = 8'h30; regs[3] = 8'hB4;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_write", 32'(ym_write),    32'd0);
    check("rst_addr",  32'(ym_addr),     32'd0);
    check("rst_din",   32'(ym_din),      32'd0);
    check("rst_ready", 32'(cmd_ready),   32'd1);
    check("rst_idle",  32'(idle),        32'd1);
    check("rst_level", 32'(fifo_level),  32'd0);
    check("rst_err",   32'(timeout_err), 32'd0);

    // Single write, then a second entry that must wait out a 40-cycle busy pulse
    busy_mode = 1; busy_len = 40;
    s0 = slog.size();
    push1(1'b0, 8'h28, 8'hF0);
    check("single_pre_write", 32'(ym_write),   32'd0);
    check("single_pre_level", 32'(fifo_level), 32'd1);
    @(negedge clk);
    check("single_addr_write", 32'(ym_write), 32'd1);
    check("single_addr_addr",  32'(ym_addr),  32'd0);
    check("single_addr_din",   32'(ym_din),   32'h28);
    repeat (2 * HOLD) @(negedge clk);
    check("single_data_write", 32'(ym_write), 32'd1);
    check("single_data_addr",  32'(ym_addr),  32'd1);
    check("single_data_din",   32'(ym_din),   32'hF0);
    push1(1'b1, 8'h2B, 8'h0F);
    wait_idle("single_idle", 400);
    check("single_strobes", 32'(slog.size() - s0), 32'd4);
    if (slog.size() - s0 == 4) begin
      check("single_next_addr", 32'(slog[s0 + 2].a), 32'd2);
      check("single_next_din",  32'(slog[s0 + 2].d), 32'h2B);
      check("single_busy_gap",  32'(slog[s0 + 2].c - slog[s0 + 1].c), 32'(busy_len + 2));
    end

    // Back-to-back: 20 entries into a 16-deep FIFO
    busy_mode = 1; busy_len = 8;
    s0 = slog.size(); i = 0; guard = 0; max_lvl = 0; saw_full = 1'b0;
    @(negedge clk);
    while (i < 20 && guard < 3000) begin
      cmd_valid = 1'b1; cmd_part = i[0];
      cmd_reg = 8'(8'h60 + i); cmd_data = 8'(8'h40 + i);
      rdy = cmd_ready;
      @(negedge clk);
      guard++;
      if (rdy) i++;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (!cmd_ready) saw_full = 1'b1;
    end
    cmd_valid = 1'b0;
    check("b2b_pushed",   32'(i),        32'd20);
    check("b2b_maxlevel", 32'(max_lvl),  32'd16);
    check("b2b_full",     32'(saw_full), 32'd1);
    wait_idle("b2b_idle", 2000);
    nd = 0;
    for (int j = s0; j < slog.size(); j++) begin
      if (slog[j].a[0]) begin
        check("b2b_data_din",  32'(slog[j].d),    32'(8'(8'h40 + nd)));
        check("b2b_data_part", 32'(slog[j].a[1]), 32'(nd % 2));
        nd++;
      end
    end
    check("b2b_data_count", 32'(nd), 32'd20);

    // Timeout: busy stuck high
    busy_mode = 2;
    s0 = slog.size();
    push1(1'b0, 8'hB0, 8'h01);
    push1(1'b1, 8'hB1, 8'h02);
    guard = 0;
    while (timeout_err !== 1'b1 && guard < 1500) begin
      @(negedge clk);
      guard++;
    end
    t_err = cyc;
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    if (slog.size() - s0 >= 2)
      check("tmo_gap", 32'(t_err - slog[s0 + 1].c), 32'(2 * HOLD + SETTLE + TIMEOUT));
    busy_mode = 1; busy_len = 5;
    wait_idle("tmo_idle", 200);
    check("tmo_strobes", 32'(slog.size() - s0), 32'd4);
    if (slog.size() - s0 == 4) check("tmo_next_din", 32'(slog[s0 + 3].d), 32'h02);
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("tmo_err_clr", 32'(timeout_err), 32'd0);

    // Flush during the first entry's data strobe
    busy_mode = 1; busy_len = 5;
    s0 = slog.size();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_part = 1'b0; cmd_reg = 8'(8'hD0 + j); cmd_data = 8'(j);
    end
    @(negedge clk); cmd_valid = 1'b0;
    guard = 0;
    while (!(ym_write === 1'b1 && ym_addr[0] === 1'b1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("flush_level_before", 32'(fifo_level), 32'd4);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_level_after", 32'(fifo_level), 32'd0);
    wait_idle("flush_idle", 200);
    check("flush_strobes", 32'(slog.size() - s0), 32'd2);

    // Repeated address: with the cache only the data strobe is issued
    busy_mode = 1; busy_len = 5;
    push1(1'b1, 8'hA4, 8'h11);
    wait_idle("cache_idle1", 200);
    s0 = slog.size();
    push1(1'b1, 8'hA4, 8'h22);
    wait_idle("cache_idle2", 200);
    if (CACHE_ON) begin
      check("cache_strobes", 32'(slog.size() - s0), 32'd1);
      if (slog.size() - s0 >= 1) check("cache_first_addr", 32'(slog[s0].a), 32'd3);
    end else begin
      check("cache_strobes", 32'(slog.size() - s0), 32'd2);
      if (slog.size() - s0 >= 1) check("cache_first_addr", 32'(slog[s0].a), 32'd2);
    end
    if (slog.size() > s0) check("cache_last_din", 32'(slog[slog.size() - 1].d), 32'h22);

    // Reset during the address strobe
    push1(1'b0, 8'hC3, 8'h5A);
    push1(1'b0, 8'hC4, 8'h5B);
    guard = 0;
    while (!(ym_write === 1'b1 && ym_addr[0] === 1'b0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rstmid_write", 32'(ym_write),   32'd0);
    check("rstmid_level", 32'(fifo_level), 32'd0);
    check("rstmid_idle",  32'(idle),       32'd1);
    s0 = slog.size();
    repeat (30) @(negedge clk);
    check("rstmid_no_strobes", 32'(slog.size() - s0), 32'd0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 200 == 0) begin
        busy_mode = $urandom_range(0, 2);
        if (busy_mode == 2) busy_mode = 3;
        busy_len = $urandom_range(0, 12);
      end
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_part  = 1'($urandom_range(0, 1));
      cmd_reg   = regs[$urandom_range(0, 3)];
      cmd_data  = 8'($urandom);
      flush     = ($urandom_range(0, 149) == 0);
      clr_err   = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0; flush = 1'b0; clr_err = 1'b0;
    busy_mode = 1; busy_len = 3;
    wait_idle("drain_idle", 4000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
